// File: rtl/clkdiv_multi.sv
// clkdiv_multi
// ------------------------------------------------------------------------
// This block is a central timebase. It keeps one free-running counter and
// N_CH independent programmable tick channels. Each channel produces a
// one-cycle tick every div[i] enabled cycles. It also produces a 50%-duty
// square wave that toggles on every tick. Divisors can be rewritten at
// runtime through a single-cycle write port.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   en        global count enable (low freezes every counter)
//   wr_en     divisor write strobe (one cycle)
//   wr_ch     channel index for the write (indices >= N_CH are ignored)
//   wr_div    new divisor value (0 disables the channel)
//   free_cnt  free-running counter, wraps silently
//   tick      per-channel single-cycle pulse, registered
//   clk_sq    per-channel square wave, registered
// ------------------------------------------------------------------------
module clkdiv_multi #(
    parameter int                 CNT_W       = 32,
    parameter int                 N_CH        = 4,
    parameter int                 DIV_W       = 16,
    parameter logic [DIV_W-1:0]   DEFAULT_DIV = 16'd2,
    parameter int                 CH_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic [CNT_W-1:0] free_cnt,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_sq
);

    logic [CNT_W-1:0] free_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt_reg <= '0;
        end else if (en) begin
            free_cnt_reg <= free_cnt_reg + CNT_W'(1);
        end
    end

    assign free_cnt = free_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_reg;
            logic [DIV_W-1:0] cnt_reg;
            logic             tick_reg;
            logic             sq_reg;
            logic             wr_hit;
            logic             at_terminal;

            // An out-of-range wr_ch matches no channel, so such a write
            // falls through to normal counting everywhere.
            assign wr_hit      = wr_en && (wr_ch == CH_W'(gi));
            assign at_terminal = (cnt_reg == (div_reg - DIV_W'(1)));

            // The branch order is the channel priority. A write beats the
            // disabled check, and both beat en. So a write landing on a
            // terminal edge suppresses that tick and that toggle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_reg  <= DEFAULT_DIV;
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                    sq_reg   <= 1'b0;
                end else if (wr_hit) begin
                    div_reg  <= wr_div;
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                end else if (div_reg == '0) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                end else if (!en) begin
                    // Hold cnt so the phase survives the freeze.
                    tick_reg <= 1'b0;
                end else if (at_terminal) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                    sq_reg   <= ~sq_reg;
                end else begin
                    cnt_reg  <= cnt_reg + DIV_W'(1);
                    tick_reg <= 1'b0;
                end
            end

            assign tick[gi]   = tick_reg;
            assign clk_sq[gi] = sq_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi. The stimulus process pushes an
// expected output set after each rising edge. The monitor pops that entry
// at the following falling edge and compares it against the DUT.
module tb_clkdiv_multi;

    typedef struct {
        string       name;
        logic [31:0] fc;
        bit          fc_chk;
        logic [3:0]  tk;
        logic [3:0]  tk_m;
        logic [3:0]  sq;
        logic [3:0]  sq_m;
        logic [3:0]  wfc;
        bit          wfc_chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, wr_en;
    logic [3:0]  wr_ch;
    logic [15:0] wr_div;
    logic [31:0] free_cnt;
    logic [3:0]  tick, clk_sq;

    logic        rst2, en2, wr_en2;
    logic [3:0]  wr_ch2;
    logic [15:0] wr_div2;
    logic [3:0]  free_cnt2;
    logic [3:0]  tick2, clk_sq2;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    clkdiv_multi dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .free_cnt(free_cnt), .tick(tick), .clk_sq(clk_sq)
    );

    clkdiv_multi #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst2), .en(en2), .wr_en(wr_en2), .wr_ch(wr_ch2),
        .wr_div(wr_div2), .free_cnt(free_cnt2), .tick(tick2), .clk_sq(clk_sq2)
    );

    function automatic exp_t mk(input string name, input logic [31:0] fc,
                                input logic [3:0] tk, input logic [3:0] tk_m,
                                input logic [3:0] sq, input logic [3:0] sq_m);
        exp_t e;
        e.name = name; e.fc = fc; e.fc_chk = 1'b1;
        e.tk = tk; e.tk_m = tk_m; e.sq = sq; e.sq_m = sq_m;
        e.wfc = 4'd0; e.wfc_chk = 1'b0;
        return e;
    endfunction

    task automatic step(input exp_t e);
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one line per popped transaction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            int bad;
            bad = 0;
            cur = sb.pop_front();
            if (cur.fc_chk) begin
                checks++;
                if (free_cnt !== cur.fc) begin
                    errors++; bad++;
                    $display("FAIL %s free_cnt got %0d want %0d", cur.name, free_cnt, cur.fc);
                end
            end
            if (cur.tk_m != 4'd0) begin
                checks++;
                if ((tick & cur.tk_m) !== (cur.tk & cur.tk_m)) begin
                    errors++; bad++;
                    $display("FAIL %s tick got %b want %b (mask %b)", cur.name, tick, cur.tk, cur.tk_m);
                end
            end
            if (cur.sq_m != 4'd0) begin
                checks++;
                if ((clk_sq & cur.sq_m) !== (cur.sq & cur.sq_m)) begin
                    errors++; bad++;
                    $display("FAIL %s clk_sq got %b want %b (mask %b)", cur.name, clk_sq, cur.sq, cur.sq_m);
                end
            end
            if (cur.wfc_chk) begin
                checks++;
                if (free_cnt2 !== cur.wfc) begin
                    errors++; bad++;
                    $display("FAIL %s free_cnt(w4) got %0d want %0d", cur.name, free_cnt2, cur.wfc);
                end
            end
            if (bad == 0) $display("[%0t] %s ok", $time, cur.name);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t, s;
        exp_t       e;
        int         m;
        int         fc3[9] = '{1, 2, 3, 3, 3, 3, 4, 5, 6};
        bit         en3[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        bit         t03[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        bit         s03[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        bit         t13[9] = '{0, 1, 0, 0, 0, 0, 1, 0, 1};
        bit         s13[9] = '{0, 1, 1, 1, 1, 1, 0, 0, 1};

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = 4'd0; wr_div = 16'd0;
        rst2 = 1'b1; en2 = 1'b0; wr_en2 = 1'b0; wr_ch2 = 4'd0; wr_div2 = 16'd0;
        repeat (2) @(negedge clk);

        // 1. Reset state and defaults (div = 2 everywhere).
        step(mk("reset", 0, 4'h0, 4'hF, 4'h0, 4'hF));
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            t = {4{k % 2 == 0}};
            s = {4{(k / 2) % 2 == 1}};
            step(mk($sformatf("default_k%0d", k), k, t, 4'hF, s, 4'hF));
        end
        // An asynchronous reset between edges must clear everything before the next edge.
        @(posedge clk);
        #2 rst = 1'b1;
        sb.push_back(mk("async_rst", 0, 4'h0, 4'hF, 4'h0, 4'hF));
        @(negedge clk);
        step(mk("rst_hold", 0, 4'h0, 4'hF, 4'h0, 4'hF));

        // 2. Reprogramming: ch0 gets div 5 at edge 1, ch1 gets div 1 at edge 2,
        //    ch2 gets div 0 at edge 3, and ch3 keeps div 2.
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            wr_en  = (k <= 3);
            wr_ch  = (k == 1) ? 4'd0 : (k == 2) ? 4'd1 : 4'd2;
            wr_div = (k == 1) ? 16'd5 : (k == 2) ? 16'd1 : 16'd0;
            m = k - 1;
            t[0] = (m > 0) && (m % 5 == 0);
            s[0] = ((m / 5) % 2 == 1);
            t[1] = (k >= 3);
            s[1] = (k >= 3) && ((k - 2) % 2 == 1);
            t[2] = (k == 2);
            s[2] = (k >= 2);
            t[3] = (k % 2 == 0);
            s[3] = ((k / 2) % 2 == 1);
            step(mk($sformatf("reprog_k%0d", k), k, t, 4'hF, s, 4'hF));
        end
        wr_en = 1'b0;

        // 3. Freeze: ch0 div 4, two enabled cycles, three frozen, then resume.
        rst = 1'b1;
        step(mk("rst_t3", 0, 4'h0, 4'hF, 4'h0, 4'hF));
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            en     = en3[k-1];
            wr_en  = (k == 1);
            wr_ch  = 4'd0;
            wr_div = 16'd4;
            t = {2'b00, t13[k-1], t03[k-1]};
            s = {2'b00, s13[k-1], s03[k-1]};
            step(mk($sformatf("freeze_k%0d", k), fc3[k-1], t, 4'h3, s, 4'h3));
        end
        wr_en = 1'b0; en = 1'b1;

        // 4. Write/terminal collision: ch0 div 3 is rewritten to 6 on the edge
        //    where cnt[0]==2. Channels 1-3 keep div 2.
        rst = 1'b1;
        step(mk("rst_t4", 0, 4'h0, 4'hF, 4'h0, 4'hF));
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            wr_en  = (k == 1) || (k == 4);
            wr_ch  = 4'd0;
            wr_div = (k == 1) ? 16'd3 : 16'd6;
            t = {3{k % 2 == 0}} << 1;
            s = {3{(k / 2) % 2 == 1}} << 1;
            t[0] = (k == 10);
            s[0] = (k >= 10);
            step(mk($sformatf("collide_k%0d", k), k, t, 4'hF, s, 4'hF));
        end
        wr_en = 1'b0;

        // 5. Invalid channel writes (4 and 15) change nothing.
        rst = 1'b1;
        step(mk("rst_t5", 0, 4'h0, 4'hF, 4'h0, 4'hF));
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wr_en  = (k <= 2);
            wr_ch  = (k == 1) ? 4'd4 : 4'd15;
            wr_div = (k == 1) ? 16'd7 : 16'd0;
            t = {4{k % 2 == 0}};
            s = {4{(k / 2) % 2 == 1}};
            step(mk($sformatf("badch_k%0d", k), k, t, 4'hF, s, 4'hF));
        end
        wr_en = 1'b0;

        // 6. Wraparound on a 4-bit instance: 0..15 then 0..3.
        e = mk("wrap_k0", 0, 4'h0, 4'h0, 4'h0, 4'h0);
        e.fc_chk = 1'b0; e.wfc = 4'd0; e.wfc_chk = 1'b1;
        step(e);
        rst2 = 1'b0; en2 = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            e = mk($sformatf("wrap_k%0d", k), 0, 4'h0, 4'h0, 4'h0, 4'h0);
            e.fc_chk = 1'b0; e.wfc = 4'(k % 16); e.wfc_chk = 1'b1;
            step(e);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard entries left got %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
